// File: rtl/ex_mem_result_stage_if.sv
// ex_mem_result_stage_if
// Bundles the EX->stage beat (valid/ready plus ALU result, flags, branch info
// and control bits), the stage->MEM beat (valid/ready plus payload) and the
// PC redirect outputs.
//   slave  : the result stage (consumes the EX beat, produces the MEM beat)
//   master : the surrounding pipeline / testbench
interface ex_mem_result_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    // EX side
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic              alu_one;
    logic              alu_comp;
    logic [2:0]        br_type;
    logic [DATA_W-1:0] br_target;
    logic [REG_W-1:0]  rd_addr;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] store_data;
    // MEM side
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [DATA_W-1:0] out_store_data;
    logic [REG_W-1:0]  out_rd;
    logic              out_reg_write;
    logic              out_mem_read;
    logic              out_mem_write;
    // PC redirect
    logic              redirect;
    logic [DATA_W-1:0] redirect_pc;

    modport slave (
        input  in_valid, alu_result, alu_zero, alu_one, alu_comp, br_type,
               br_target, rd_addr, reg_write, mem_read, mem_write, store_data,
               out_ready,
        output in_ready, out_valid, out_result, out_store_data, out_rd,
               out_reg_write, out_mem_read, out_mem_write, redirect, redirect_pc
    );

    modport master (
        output in_valid, alu_result, alu_zero, alu_one, alu_comp, br_type,
               br_target, rd_addr, reg_write, mem_read, mem_write, store_data,
               out_ready,
        input  in_ready, out_valid, out_result, out_store_data, out_rd,
               out_reg_write, out_mem_read, out_mem_write, redirect, redirect_pc
    );
endinterface

// File: rtl/ex_mem_result_stage.sv
// ex_mem_result_stage
// Consumer end of the ALU result/flag path between EX and MEM.
//  - Branch beats (beq/bne/bltz/bgez) are resolved from the ALU flags and
//    consumed; a taken branch gives a one-cycle redirect pulse with its target.
//  - Non-branch beats pass through a 2-entry skid buffer (main + skid) so that
//    in_ready is a pure register output, with no combinational path from
//    out_ready back into EX.
// Ports:
//  clk, rst : rising-edge clock, synchronous active-high reset
//  bus      : ex_mem_result_stage_if.slave (EX beat in, MEM beat out, redirect)
//  br_taken_cnt, br_total_cnt : branch statistics, only when BRANCH_STATS_EN
//                               is defined
// Optional macro: BRANCH_STATS_EN adds the two 32-bit wrapping counters.
module ex_mem_result_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic clk,
    input  logic rst,
    ex_mem_result_stage_if.slave bus
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0] br_taken_cnt,
    output logic [31:0] br_total_cnt
`endif
);
    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [DATA_W-1:0] store_data;
        logic [REG_W-1:0]  rd;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
    } beat_t;

    beat_t             in_beat;
    beat_t             main_reg, main_next;
    beat_t             skid_reg, skid_next;
    logic              main_valid_reg, main_valid_next;
    logic              skid_valid_reg, skid_valid_next;
    logic              in_ready_reg;
    logic              redirect_reg;
    logic [DATA_W-1:0] redirect_pc_reg;

    logic is_branch;
    logic taken;
    logic accept;
    logic accept_data;
    logic accept_branch;
    logic drain;

    assign in_beat = '{result:     bus.alu_result,
                       store_data: bus.store_data,
                       rd:         bus.rd_addr,
                       reg_write:  bus.reg_write,
                       mem_read:   bus.mem_read,
                       mem_write:  bus.mem_write};

    // Branch decode; reserved codes 101-111 behave as ordinary beats.
    always_comb begin
        is_branch = 1'b0;
        taken     = 1'b0;
        case (bus.br_type)
            3'b001:  begin is_branch = 1'b1; taken = bus.alu_zero; end
            3'b010:  begin is_branch = 1'b1; taken = bus.alu_one;  end
            3'b011,
            3'b100:  begin is_branch = 1'b1; taken = bus.alu_comp; end
            default: begin is_branch = 1'b0; taken = 1'b0;         end
        endcase
    end

    assign accept        = bus.in_valid & in_ready_reg;
    assign accept_data   = accept & ~is_branch;
    assign accept_branch = accept & is_branch;
    assign drain         = main_valid_reg & bus.out_ready;

    // Main/skid next state. The skid entry is only ever written while main is
    // occupied and not draining, so acceptance order is preserved.
    always_comb begin
        main_next       = main_reg;
        main_valid_next = main_valid_reg;
        skid_next       = skid_reg;
        skid_valid_next = skid_valid_reg;
        if (drain) begin
            if (skid_valid_reg) begin
                main_next       = skid_reg;
                main_valid_next = 1'b1;
                skid_valid_next = accept_data;
                if (accept_data) begin
                    skid_next = in_beat;
                end
            end else if (accept_data) begin
                main_next = in_beat;
            end else begin
                main_valid_next = 1'b0;
            end
        end else if (accept_data) begin
            if (!main_valid_reg) begin
                main_next       = in_beat;
                main_valid_next = 1'b1;
            end else begin
                skid_next       = in_beat;
                skid_valid_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_reg        <= '0;
            skid_reg        <= '0;
            main_valid_reg  <= 1'b0;
            skid_valid_reg  <= 1'b0;
            in_ready_reg    <= 1'b1;
            redirect_reg    <= 1'b0;
            redirect_pc_reg <= '0;
        end else begin
            main_reg        <= main_next;
            skid_reg        <= skid_next;
            main_valid_reg  <= main_valid_next;
            skid_valid_reg  <= skid_valid_next;
            // Ready follows skid occupancy one cycle later: never accept while
            // the skid entry holds a beat.
            in_ready_reg    <= ~skid_valid_next;
            redirect_reg    <= accept_branch & taken;
            if (accept_branch & taken) begin
                redirect_pc_reg <= bus.br_target;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] br_taken_cnt_reg;
    logic [31:0] br_total_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            br_taken_cnt_reg <= '0;
            br_total_cnt_reg <= '0;
        end else begin
            if (accept_branch) begin
                br_total_cnt_reg <= br_total_cnt_reg + 32'd1;
            end
            if (accept_branch & taken) begin
                br_taken_cnt_reg <= br_taken_cnt_reg + 32'd1;
            end
        end
    end

    assign br_taken_cnt = br_taken_cnt_reg;
    assign br_total_cnt = br_total_cnt_reg;
`endif

    assign bus.in_ready       = in_ready_reg;
    assign bus.out_valid      = main_valid_reg;
    assign bus.out_result     = main_reg.result;
    assign bus.out_store_data = main_reg.store_data;
    assign bus.out_rd         = main_reg.rd;
    assign bus.out_reg_write  = main_reg.reg_write;
    assign bus.out_mem_read   = main_reg.mem_read;
    assign bus.out_mem_write  = main_reg.mem_write;
    assign bus.redirect       = redirect_reg;
    assign bus.redirect_pc    = redirect_pc_reg;
endmodule

// File: doc/ex_mem_result_stage.md
Name: ex_mem_result_stage

Overview:
- Consumer end of the ALU result/flag interface in the pipelined MIPS core; sits between the EX-stage ALU and the MEM stage.
- Resolves conditional branches (beq, bne, bltz, bgez) from the ALU flags and issues a one-cycle PC redirect.
- Buffers non-branch results in a 2-entry skid buffer using a valid/ready handshake, so MEM-stage back-pressure does not create a combinational ready path into EX.

Parameters:
- DATA_W, 32, width of result, store data and PC.
- REG_W, 5, width of the destination register address.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  EX beat valid.
- in_ready  output  1  stage can accept a beat. Driven directly from a register (no skid entry occupied).
- alu_result  input  DATA_W  ALU result.
- alu_zero  input  1  operands equal.
- alu_one  input  1  operands not equal.
- alu_comp  input  1  sign-comparison result (bltz/bgez).
- br_type  input  3  000 none, 001 beq, 010 bne, 011 bltz, 100 bgez, 101-111 treated as none.
- br_target  input  DATA_W  branch target PC.
- rd_addr  input  REG_W  destination register.
- reg_write, mem_read, mem_write  input  1 each  control bits.
- store_data  input  DATA_W  store operand.
- out_valid  output  1  MEM beat valid.
- out_ready  input  1  MEM accepts.
- out_result, out_store_data  output  DATA_W.
- out_rd  output  REG_W.
- out_reg_write, out_mem_read, out_mem_write  output  1 each.
- redirect  output  1  one-cycle pulse: taken branch.
- redirect_pc  output  DATA_W  target valid when redirect=1.

Behaviour:
- Reset: the synchronous active-high rst, sampled on the rising edge of clk, produces:
  - out_valid=0, in_ready=1, redirect=0, redirect_pc=0.
  - All out_* payload outputs = 0.
  - Both buffer entries empty.
- Reset mid-operation discards buffered beats and any pending redirect. Nothing is emitted on the cycle after reset.
- Accept condition: in_valid & in_ready at a clk edge.
- Branch beats (br_type 001-100):
  - Taken condition: beq → alu_zero; bne → alu_one; bltz/bgez → alu_comp.
  - Branch beats are consumed and never forwarded to MEM.
  - If taken: redirect=1 and redirect_pc=br_target on the next cycle, for exactly one cycle. Latency from accept = 1.
  - If not taken: no redirect.
  - Flag inputs are ignored for non-branch beats.
- Non-branch beats (including codes 101-111):
  - Written to the main entry if it is empty or draining this cycle (out_valid & out_ready). Otherwise written to the skid entry.
  - Latency from accept to out_valid = 1 cycle.
- Output: out_* reflect the main entry. They hold stable while out_valid & !out_ready.
- Handshake: on out_valid & out_ready, the skid entry (if full) moves to main. Otherwise main refills from the input or goes empty.
- in_ready (registered):
  - Deasserts the cycle after the skid entry fills.
  - Reasserts the cycle after the skid entry empties.
- Full case: with main and skid both full, in_ready=0, so no beat can be lost.
- Simultaneous accept and drain with main full and skid empty: the new beat takes main, and the skid entry stays empty.
- Simultaneous accept and drain with skid full cannot occur (in_ready=0).
- Ordering: beats leave strictly in acceptance order.
- Back-to-back taken branches: redirect pulses on consecutive cycles, each with its own target.
- Data widths: pass-through only. No arithmetic on the payload.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- When defined, adds outputs br_taken_cnt and br_total_cnt (32 bits each).
  - br_total_cnt increments on every accepted branch beat.
  - br_taken_cnt increments on every taken branch beat.
  - Both clear on rst and wrap from 0xFFFFFFFF to 0.
- When undefined, these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset, then accept non-branch beat (alu_result=0x0000_00A5, rd=5, reg_write=1) with out_ready=1 → next cycle out_valid=1, out_result=0xA5, out_rd=5. The beat leaves the stage on that cycle.
- beq with alu_zero=1, br_target=0x0040_0100 → redirect=1 for exactly one cycle with redirect_pc=0x0040_0100. out_valid stays 0.
- bne with alu_one=0; bltz with alu_comp=0 → no redirect and no output beat.
- out_ready=0, stream 3 beats (results 1, 2, 3):
  - Beats 1 and 2 are accepted; in_ready=0 on the cycle after beat 2 is accepted; beat 3 is held.
  - Raise out_ready → outputs 1, 2, 3 in order, with no loss and no duplication.
- Assert rst while both entries are full and a redirect is pending → next cycle out_valid=0, redirect=0, in_ready=1.
- With BRANCH_STATS_EN: 4 branches, 3 taken → br_total_cnt=4, br_taken_cnt=3. Preload br_total_cnt near 0xFFFFFFFF → it wraps to 0.
